// File: rtl/prot_trig_seq.sv
// ---------------------------------------------------------------------------
// prot_trig_seq
// Trigger sequencer for the protocol-trigger path of the logic analyzer.
// It arms the protocol receivers and can wait out a holdoff window first.
// It then counts rising edges of protTrig until the programmed occurrence
// count is reached, declares the trigger, and counts post-trigger samples
// before it flags capture complete.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   arm            pulse: start a sequence (accepted in IDLE and DONE only)
//   clr            pulse: abort to IDLE (beats every other condition)
//   prot_trig_in   protTrig from the protocol trigger block (pulse or level)
//   smpl_en        capture sample strobe from the decimator
//   trig_cnt       match events required (0 behaves as 1)
//   holdoff        clk cycles after arm during which matches are ignored
//   post_cnt       samples to capture after the trigger
//   prot_en        high in ARMED only
//   armed          high in HOLDOFF or ARMED
//   triggered      high in POST or DONE
//   capture_done   high in DONE
//   match_cnt      match events counted in the current sequence
// ---------------------------------------------------------------------------
module prot_trig_seq #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned POST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              clr,
   input  logic              prot_trig_in,
   input  logic              smpl_en,
   input  logic [CNT_W-1:0]  trig_cnt,
   input  logic [POST_W-1:0] holdoff,
   input  logic [POST_W-1:0] post_cnt,
   output logic              prot_en,
   output logic              armed,
   output logic              triggered,
   output logic              capture_done,
   output logic [CNT_W-1:0]  match_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HOLDOFF = 3'd1,
      S_ARMED   = 3'd2,
      S_POST    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Event detect pipeline: r_in_q is the registered input, r_in_prev its last value
   logic                r_in_q;
   logic                r_in_prev;
   logic                w_event;

   logic [CNT_W-1:0]    r_match_cnt;
   logic [CNT_W-1:0]    w_match_nxt;
   logic [CNT_W-1:0]    w_match_inc;

   // Shadow copies taken on an accepted arm
   logic [CNT_W-1:0]    r_trig_sh;
   logic [CNT_W-1:0]    w_trig_sh_nxt;
   logic [POST_W-1:0]   r_post_sh;
   logic [POST_W-1:0]   w_post_sh_nxt;

   logic [POST_W-1:0]   r_hold_cnt;
   logic [POST_W-1:0]   w_hold_nxt;
   logic [POST_W-1:0]   r_post_cnt;
   logic [POST_W-1:0]   w_post_nxt;

   logic                r_prot_en;
   logic                r_armed;
   logic                r_triggered;
   logic                r_capture_done;

   assign w_event     = r_in_q & ~r_in_prev;
   assign w_match_inc = r_match_cnt + CNT_W'(1);

   // State register and all datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_in_q         <= 1'b0;
         r_in_prev      <= 1'b0;
         r_match_cnt    <= '0;
         r_trig_sh      <= '0;
         r_post_sh      <= '0;
         r_hold_cnt     <= '0;
         r_post_cnt     <= '0;
         r_prot_en      <= 1'b0;
         r_armed        <= 1'b0;
         r_triggered    <= 1'b0;
         r_capture_done <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_in_q         <= prot_trig_in;
         r_in_prev      <= r_in_q;
         r_match_cnt    <= w_match_nxt;
         r_trig_sh      <= w_trig_sh_nxt;
         r_post_sh      <= w_post_sh_nxt;
         r_hold_cnt     <= w_hold_nxt;
         r_post_cnt     <= w_post_nxt;
         // Outputs decoded from the next state so they line up with r_state
         r_prot_en      <= (w_state_nxt == S_ARMED);
         r_armed        <= (w_state_nxt == S_HOLDOFF) || (w_state_nxt == S_ARMED);
         r_triggered    <= (w_state_nxt == S_POST) || (w_state_nxt == S_DONE);
         r_capture_done <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state and counter update
   always_comb begin
      w_state_nxt   = r_state;
      w_match_nxt   = r_match_cnt;
      w_trig_sh_nxt = r_trig_sh;
      w_post_sh_nxt = r_post_sh;
      w_hold_nxt    = r_hold_cnt;
      w_post_nxt    = r_post_cnt;

      if (clr) begin
         w_state_nxt = S_IDLE;
         w_match_nxt = '0;
         w_hold_nxt  = '0;
         w_post_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  w_match_nxt   = '0;
                  w_trig_sh_nxt = (trig_cnt == '0) ? CNT_W'(1) : trig_cnt;
                  w_post_sh_nxt = post_cnt;
                  w_post_nxt    = '0;
                  if (holdoff == '0) begin
                     w_hold_nxt  = '0;
                     w_state_nxt = S_ARMED;
                  end else begin
                     w_hold_nxt  = holdoff;
                     w_state_nxt = S_HOLDOFF;
                  end
               end
            end

            // Leaving on a count of 1 gives exactly 'holdoff' cycles here
            S_HOLDOFF: begin
               if (r_hold_cnt <= POST_W'(1)) begin
                  w_hold_nxt  = '0;
                  w_state_nxt = S_ARMED;
               end else begin
                  w_hold_nxt  = r_hold_cnt - POST_W'(1);
               end
            end

            // r_trig_sh is at least 1, so match_cnt never passes it
            S_ARMED: begin
               if (w_event) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == r_trig_sh) begin
                     w_post_nxt  = r_post_sh;
                     w_state_nxt = S_POST;
                  end
               end
            end

            // An empty counter moves on regardless of smpl_en
            S_POST: begin
               if (r_post_cnt == '0) begin
                  w_state_nxt = S_DONE;
               end else if (smpl_en) begin
                  w_post_nxt  = r_post_cnt - POST_W'(1);
               end
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign prot_en      = r_prot_en;
   assign armed        = r_armed;
   assign triggered    = r_triggered;
   assign capture_done = r_capture_done;
   assign match_cnt    = r_match_cnt;

endmodule
